latency_bucket_reader: RTL and testbench
========================================

// Module: latency_bucket_reader
// PURPOSE
//  Readout engine for the LatencyBucket histogram: freezes sampling, sweeps every bucket id,
//  captures each count and streams (id, value, last) on a valid/ready port to host/CSR logic.
//  Optionally clears all buckets afterwards via the resetBucket/resetDone handshake.
//  Sits beside LatencyBucket and drives its io_enable, io_bucketRdId and io_resetBucket.
// PARAMETERS
//  NUM_BUCKETS  32   buckets swept, ids 0..NUM_BUCKETS-1 (need not be a power of 2)
//  ID_WIDTH     5    width of bucket id, >= clog2(NUM_BUCKETS)
//  VALUE_WIDTH  32   width of one bucket count
//  RD_LATENCY   1    cycles from io_bucketRdId change to io_bucketValue valid (>=0)
//  CLR_TIMEOUT  64   cycles to wait for io_resetDone before flagging an error
// PORTS
//  clock             in   1            single clock, all logic posedge
//  reset             in   1            asynchronous, active-high
//  io_enableReq      in   1            host wants sampling enabled while idle
//  io_dumpReq        in   1            1-cycle pulse: start a dump
//  io_clearAfterDump in   1            sampled with io_dumpReq: clear buckets after dump
//  io_enable         out  1            to LatencyBucket io_enable
//  io_bucketRdId     out  ID_WIDTH     to LatencyBucket io_bucketRdId
//  io_bucketValue    in   VALUE_WIDTH  from LatencyBucket
//  io_resetBucket    out  1            to LatencyBucket, 1-cycle pulse
//  io_resetDone      in   1            from LatencyBucket, clear complete (level or pulse)
//  io_out_valid      out  1            stream: record valid
//  io_out_ready      in   1            stream: consumer accepts
//  io_out_id         out  ID_WIDTH     bucket id of record
//  io_out_bits       out  VALUE_WIDTH  bucket count
//  io_out_last       out  1            high on record for id NUM_BUCKETS-1
//  io_total          out  VALUE_WIDTH  saturating sum of counts of current/last dump
//  io_busy           out  1            high in any state other than IDLE
//  io_dumpDone       out  1            1-cycle pulse when dump (and clear) finishes
//  io_clrTimeout     out  1            sticky; set on clear timeout, cleared by next io_dumpReq
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, id 0, total 0, io_clrTimeout 0.
//  io_enable = io_enableReq when IDLE, else 0 (registered, 1-cycle lag); sampling frozen during dump/clear.
//  FSM: IDLE -io_dumpReq-> SETTLE (2 cycles, lets enable drop propagate) -> ADDR.
//   ADDR: drive io_bucketRdId = id; wait RD_LATENCY cycles (WAIT) then capture io_bucketValue into out regs.
//   SEND: io_out_valid=1; id/bits/last stable until io_out_valid&&io_out_ready; on handshake
//     total += bits (saturate at all-ones); if id==NUM_BUCKETS-1 -> CLEAR or DONE, else id+1 -> ADDR.
//   CLEAR (if clear latched): io_resetBucket=1 for exactly one cycle -> WAIT_CLR.
//   WAIT_CLR: exit on io_resetDone==1 -> DONE; after CLR_TIMEOUT cycles set io_clrTimeout -> DONE.
//   DONE: io_dumpDone=1 one cycle, id<=0 -> IDLE.
//  io_total zeroed on accepted io_dumpReq, holds after DONE until next dump.
//  io_dumpReq while busy: ignored, no queuing. io_clearAfterDump latched only with accepted req.
//  io_out_ready may be held low indefinitely; no record dropped or duplicated; bits not resampled.
//  Id never exceeds NUM_BUCKETS-1; no wrap to 0 mid-dump.
//  RD_LATENCY=0: capture in the same ADDR cycle (WAIT skipped).
//  Reset mid-dump: immediate return to IDLE, stream valid drops; no clear is issued.
// STRUCTURE
//  Package latency_bucket_pkg: state enum (IDLE,SETTLE,ADDR,WAIT,SEND,CLEAR,WAIT_CLR,DONE),
//   default widths, NUM_BUCKETS; shared with LatencyBucket.
//  Single module, no sub-modules; saturating adder is an inline function in the package.
// TESTING
//  Preload buckets 0..31 with value id*3, dump, ready=1 -> 32 records id 0..31, bits=id*3, last only on 31,
//   io_total=1488, io_dumpDone pulse once, io_resetBucket never asserted.
//  Same with io_clearAfterDump=1, resetDone 4 cycles after pulse -> one io_resetBucket pulse, buckets read 0 after.
//  Ready toggled random 30% -> identical record sequence, out_bits/id stable whenever valid&&!ready.
//  Bucket values 0xFFFF_FFF0 x2 -> io_total saturates at 0xFFFF_FFFF.
//  resetDone never asserted -> io_clrTimeout=1 after 64 cycles, io_dumpDone pulses, next dumpReq clears flag.
//  Reset asserted at id 10 / dumpReq during busy -> IDLE, all outputs 0 / request ignored, sequence unchanged.

Source files
------------

// File: rtl/latency_bucket_pkg.sv
// Shared types and defaults for the LatencyBucket histogram and its readout engine.
package latency_bucket_pkg;

  localparam int unsigned DEF_NUM_BUCKETS = 32;
  localparam int unsigned DEF_ID_WIDTH    = 5;
  localparam int unsigned DEF_VALUE_WIDTH = 32;
  localparam int unsigned DEF_RD_LATENCY  = 1;
  localparam int unsigned DEF_CLR_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ADDR,
    WAIT,
    SEND,
    CLEAR,
    WAIT_CLR,
    DONE
  } state_t;

  // Unsigned add that clamps at the all-ones value of a w-bit field (w <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (65'd1 << w) - 65'd1;
    return (sum > max) ? max[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/latency_bucket_reader.sv
// Readout engine for LatencyBucket: freezes sampling, sweeps all bucket ids, streams
// (id, value, last) records and optionally clears the histogram afterwards.
module latency_bucket_reader
  import latency_bucket_pkg::*;
#(
  parameter int unsigned NUM_BUCKETS = DEF_NUM_BUCKETS,
  parameter int unsigned ID_WIDTH    = DEF_ID_WIDTH,
  parameter int unsigned VALUE_WIDTH = DEF_VALUE_WIDTH,
  parameter int unsigned RD_LATENCY  = DEF_RD_LATENCY,
  parameter int unsigned CLR_TIMEOUT = DEF_CLR_TIMEOUT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_enableReq,
  input  logic                   io_dumpReq,
  input  logic                   io_clearAfterDump,
  output logic                   io_enable,
  output logic [ID_WIDTH-1:0]    io_bucketRdId,
  input  logic [VALUE_WIDTH-1:0] io_bucketValue,
  output logic                   io_resetBucket,
  input  logic                   io_resetDone,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [ID_WIDTH-1:0]    io_out_id,
  output logic [VALUE_WIDTH-1:0] io_out_bits,
  output logic                   io_out_last,
  output logic [VALUE_WIDTH-1:0] io_total,
  output logic                   io_busy,
  output logic                   io_dumpDone,
  output logic                   io_clrTimeout
);

  localparam int unsigned CNT_MAX = (CLR_TIMEOUT > RD_LATENCY) ? CLR_TIMEOUT : RD_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 2);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_BUCKETS - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]  id_q;
  logic                 clr_q;
  logic                 accept_c;
  logic                 capture_c;
  logic                 handshake_c;
  logic                 timeout_c;
  logic [VALUE_WIDTH-1:0] total_sum_c;

  assign io_bucketRdId = id_q;
  assign total_sum_c   = VALUE_WIDTH'(sat_add(64'(io_total), 64'(io_out_bits), VALUE_WIDTH));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and per-cycle strobes; the shared counter restarts on every state change.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    accept_c    = 1'b0;
    capture_c   = 1'b0;
    handshake_c = 1'b0;
    timeout_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_dumpReq) begin
          accept_c = 1'b1;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(1)) state_d = ADDR;
      end
      ADDR: begin
        if (RD_LATENCY == 0) begin
          capture_c = 1'b1;
          state_d   = SEND;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(RD_LATENCY - 1)) begin
          capture_c = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (io_out_ready) begin
          handshake_c = 1'b1;
          if (id_q == LAST_ID) state_d = clr_q ? CLEAR : DONE;
          else                 state_d = ADDR;
        end
      end
      CLEAR:    state_d = WAIT_CLR;
      WAIT_CLR: begin
        if (io_resetDone) begin
          state_d = DONE;
        end else if (cnt_q == CNT_W'(CLR_TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Datapath and registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_q           <= '0;
      clr_q          <= 1'b0;
      io_enable      <= 1'b0;
      io_resetBucket <= 1'b0;
      io_out_valid   <= 1'b0;
      io_out_id      <= '0;
      io_out_bits    <= '0;
      io_out_last    <= 1'b0;
      io_total       <= '0;
      io_busy        <= 1'b0;
      io_dumpDone    <= 1'b0;
      io_clrTimeout  <= 1'b0;
    end else begin
      io_enable      <= io_enableReq && (state_d == IDLE);
      io_busy        <= (state_d != IDLE);
      io_out_valid   <= (state_d == SEND);
      io_resetBucket <= (state_d == CLEAR);
      io_dumpDone    <= (state_d == DONE);
      if (accept_c) begin
        clr_q         <= io_clearAfterDump;
        io_total      <= '0;
        io_clrTimeout <= 1'b0;
      end
      if (capture_c) begin
        io_out_id   <= id_q;
        io_out_bits <= io_bucketValue;
        io_out_last <= (id_q == LAST_ID);
      end
      if (handshake_c) begin
        io_total <= total_sum_c;
        if (id_q != LAST_ID) id_q <= id_q + ID_WIDTH'(1);
      end
      if (timeout_c)        io_clrTimeout <= 1'b1;
      if (state_q == DONE)  id_q <= '0;
    end
  end

endmodule

// File: tb/tb_latency_bucket_reader.sv
// Directed bench for latency_bucket_reader with a registered-read bucket memory model.
module tb_latency_bucket_reader;

  localparam int unsigned NB = 32;
  localparam int unsigned IW = 5;
  localparam int unsigned VW = 32;

  logic          clock;
  logic          reset;
  logic          enable_req;
  logic          dump_req;
  logic          clear_after;
  logic          enable;
  logic [IW-1:0] rd_id;
  logic [VW-1:0] bucket_value;
  logic          reset_bucket;
  logic          rst_done;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_id;
  logic [VW-1:0] out_bits;
  logic          out_last;
  logic [VW-1:0] total;
  logic          busy;
  logic          dump_done;
  logic          clr_timeout;

  latency_bucket_reader dut (
    .clock            (clock),
    .reset            (reset),
    .io_enableReq     (enable_req),
    .io_dumpReq       (dump_req),
    .io_clearAfterDump(clear_after),
    .io_enable        (enable),
    .io_bucketRdId    (rd_id),
    .io_bucketValue   (bucket_value),
    .io_resetBucket   (reset_bucket),
    .io_resetDone     (rst_done),
    .io_out_valid     (out_valid),
    .io_out_ready     (out_ready),
    .io_out_id        (out_id),
    .io_out_bits      (out_bits),
    .io_out_last      (out_last),
    .io_total         (total),
    .io_busy          (busy),
    .io_dumpDone      (dump_done),
    .io_clrTimeout    (clr_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bucket memory: one-cycle registered read; reads zero once a clear has completed.
  logic [VW-1:0] mem [NB];
  int unsigned   load_gen = 0;
  int unsigned   clr_gen  = 0;
  logic          done_en  = 1'b1;
  int            cd       = 0;
  int            ready_mode = 0;

  always @(posedge clock) bucket_value <= (clr_gen != load_gen) ? '0 : mem[rd_id];

  always @(posedge clock) begin
    rst_done <= 1'b0;
    if (reset) cd <= 0;
    else if (reset_bucket) cd <= 4;
    else if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 1 && done_en) begin
        rst_done <= 1'b1;
        clr_gen  <= clr_gen + 1;
      end
    end
  end

  always @(negedge clock)
    out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) >= 30);

  // Stream recorder and stall-stability monitor.
  logic [IW-1:0] rec_id   [1024];
  logic [VW-1:0] rec_bits [1024];
  logic          rec_last [1024];
  int            n_rec = 0, dd_cyc = 0, rb_cyc = 0, stab_err = 0;
  logic          prev_stall = 1'b0;
  logic [IW-1:0] p_id;
  logic [VW-1:0] p_bits;
  logic          p_last;

  always @(posedge clock) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (out_valid && out_ready && n_rec < 1024) begin
        rec_id[n_rec]   <= out_id;
        rec_bits[n_rec] <= out_bits;
        rec_last[n_rec] <= out_last;
        n_rec           <= n_rec + 1;
      end
      if (prev_stall && (!out_valid || out_id != p_id || out_bits != p_bits || out_last != p_last))
        stab_err <= stab_err + 1;
      prev_stall <= out_valid && !out_ready;
      p_id       <= out_id;
      p_bits     <= out_bits;
      p_last     <= out_last;
      if (dump_done)    dd_cyc <= dd_cyc + 1;
      if (reset_bucket) rb_cyc <= rb_cyc + 1;
    end
  end

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [VW-1:0] exp_bits(input int i, input int mode);
    if (mode == 0) return VW'(i * 3);
    if (mode == 2) return (i < 2) ? 32'hFFFF_FFF0 : 32'h0;
    return '0;
  endfunction

  task automatic load(input int mode);
    for (int i = 0; i < NB; i++) mem[i] = exp_bits(i, mode);
    load_gen = clr_gen;
  endtask

  task automatic start_dump(input logic clr);
    dump_req    = 1'b1;
    clear_after = clr;
    tick(1);
    dump_req    = 1'b0;
    clear_after = 1'b0;
  endtask

  task automatic wait_done();
    int base = dd_cyc;
    int k = 0;
    while (dd_cyc == base && k < 20000) begin
      tick(1);
      k++;
    end
    chk("done_seen", 64'(dd_cyc != base), 64'd1);
    tick(2);
  endtask

  task automatic check_records(input int base, input int mode);
    chk("rec_count", 64'(n_rec - base), 64'd32);
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("rec_id[%0d]", i), 64'(rec_id[base + i]), 64'(i));
      chk($sformatf("rec_bits[%0d]", i), 64'(rec_bits[base + i]), 64'(exp_bits(i, mode)));
      chk($sformatf("rec_last[%0d]", i), 64'(rec_last[base + i]), 64'(i == NB - 1));
    end
  endtask

  initial begin
    int base, dd0, rb0, k;
    reset       = 1'b1;
    enable_req  = 1'b0;
    dump_req    = 1'b0;
    clear_after = 1'b0;
    tick(3);
    chk("rst_ctrl", 64'({enable, reset_bucket, out_valid, out_last, busy, dump_done, clr_timeout}), 64'd0);
    chk("rst_rd_id", 64'(rd_id), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_bits", 64'(out_bits), 64'd0);
    chk("rst_total", 64'(total), 64'd0);
    reset = 1'b0;
    tick(1);
    enable_req = 1'b1;
    tick(1);
    chk("idle_enable", 64'(enable), 64'd1);

    // Plain dump, ready always high.
    load(0);
    base = n_rec; dd0 = dd_cyc; rb0 = rb_cyc;
    start_dump(1'b0);
    tick(3);
    chk("dump_enable_low", 64'(enable), 64'd0);
    chk("dump_busy", 64'(busy), 64'd1);
    wait_done();
    check_records(base, 0);
    chk("t1_total", 64'(total), 64'd1488);
    chk("t1_done_pulses", 64'(dd_cyc - dd0), 64'd1);
    chk("t1_no_clear", 64'(rb_cyc - rb0), 64'd0);
    chk("t1_busy_after", 64'(busy), 64'd0);
    chk("t1_enable_after", 64'(enable), 64'd1);

    // Dump with clear, then a second dump reads zeros.
    load(0);
    base = n_rec; rb0 = rb_cyc;
    start_dump(1'b1);
    wait_done();
    check_records(base, 0);
    chk("t2_clear_pulses", 64'(rb_cyc - rb0), 64'd1);
    chk("t2_no_timeout", 64'(clr_timeout), 64'd0);
    chk("t2_total", 64'(total), 64'd1488);
    base = n_rec;
    start_dump(1'b0);
    wait_done();
    check_records(base, 1);
    chk("t2_total_zero", 64'(total), 64'd0);

    // Random back-pressure.
    load(0);
    ready_mode = 1;
    base = n_rec;
    start_dump(1'b0);
    wait_done();
    ready_mode = 0;
    check_records(base, 0);
    chk("t3_stable", 64'(stab_err), 64'd0);
    chk("t3_total", 64'(total), 64'd1488);

    // Saturating total.
    load(2);
    base = n_rec;
    start_dump(1'b0);
    wait_done();
    check_records(base, 2);
    chk("t4_total_sat", 64'(total), 64'hFFFF_FFFF);

    // Clear timeout, then flag cleared by next request.
    done_en = 1'b0;
    load(0);
    dd0 = dd_cyc; rb0 = rb_cyc;
    start_dump(1'b1);
    wait_done();
    chk("t5_timeout", 64'(clr_timeout), 64'd1);
    chk("t5_done_pulses", 64'(dd_cyc - dd0), 64'd1);
    chk("t5_clear_pulses", 64'(rb_cyc - rb0), 64'd1);
    done_en = 1'b1;
    start_dump(1'b0);
    chk("t5_flag_cleared", 64'(clr_timeout), 64'd0);
    wait_done();
    chk("t5_flag_stays", 64'(clr_timeout), 64'd0);

    // Reset at id 10 with a clear requested: no clear, no done.
    load(0);
    dd0 = dd_cyc; rb0 = rb_cyc;
    start_dump(1'b1);
    k = 0;
    while (!(out_valid && out_id == IW'(10)) && k < 2000) begin
      tick(1);
      k++;
    end
    chk("t6_reached_id10", 64'(out_valid && out_id == IW'(10)), 64'd1);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_ctrl", 64'({enable, reset_bucket, out_valid, out_last, busy, dump_done, clr_timeout}), 64'd0);
    chk("t6_rst_rd_id", 64'(rd_id), 64'd0);
    chk("t6_rst_total", 64'(total), 64'd0);
    reset = 1'b0;
    tick(80);
    chk("t6_no_clear", 64'(rb_cyc - rb0), 64'd0);
    chk("t6_no_done", 64'(dd_cyc - dd0), 64'd0);
    chk("t6_idle", 64'(busy), 64'd0);

    // Request while busy is ignored and does not latch its clear flag.
    base = n_rec; dd0 = dd_cyc; rb0 = rb_cyc;
    start_dump(1'b0);
    tick(20);
    start_dump(1'b1);
    wait_done();
    check_records(base, 0);
    chk("t7_total", 64'(total), 64'd1488);
    chk("t7_no_clear", 64'(rb_cyc - rb0), 64'd0);
    tick(200);
    chk("t7_not_queued", 64'(dd_cyc - dd0), 64'd1);
    chk("t7_no_extra_recs", 64'(n_rec - base), 64'd32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
